// File: rtl/prbs7_pkg.sv
// prbs7_pkg: shared constants and the 64-bit PRBS7 (x^7+x^6+1) word function
package prbs7_pkg;
  localparam int PRBS7_W = 7;
  localparam int WORD_W = 64;
  localparam logic [PRBS7_W-1:0] PRBS7_DEFAULT_SEED = 7'h7F;
  function automatic logic [PRBS7_W-1:0] prbs7_fix_seed(input logic [PRBS7_W-1:0] s);
    return (s == '0) ? PRBS7_DEFAULT_SEED : s;
  endfunction
  function automatic logic [WORD_W-1:0] prbs7_next_word(input logic [PRBS7_W-1:0] state);
    logic [PRBS7_W-1:0] s;
    logic [WORD_W-1:0] w;
    s = state;
    w = '0;
    for (int i = 0; i < WORD_W; i++) begin
      w[i] = s[1] ^ s[0];
      s = {w[i], s[PRBS7_W-1:1]};
    end
    return w;
  endfunction
endpackage

// File: rtl/prbs7_word_gen.sv
// prbs7_word_gen: combinational 64-step PRBS7 unroll from a 7-bit state
module prbs7_word_gen
  import prbs7_pkg::*;
(
  input  logic [PRBS7_W-1:0] state_i,
  output logic [WORD_W-1:0]  word_o
);
  assign word_o = prbs7_next_word(state_i);
endmodule

// File: rtl/prbs7_gen.sv
// prbs7_gen: 64-bit PRBS7 transmit generator with flow control, seeding and error injection
module prbs7_gen
  import prbs7_pkg::*;
#(
  parameter logic [PRBS7_W-1:0] SEED = PRBS7_DEFAULT_SEED,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               seed_load,
  input  logic [PRBS7_W-1:0] seed_in,
  input  logic               inj_req,
  input  logic [5:0]         inj_pos,
  output logic [WORD_W-1:0]  dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               inj_pending,
  output logic [CNT_W-1:0]   word_cnt,
  output logic [CNT_W-1:0]   inj_cnt
);
  logic [PRBS7_W-1:0] state_q, state_d;
  logic [WORD_W-1:0] dout_q, dout_d, clean, mask;
  logic valid_q, valid_d, pend_q, pend_d, flag_q, flag_d;
  logic [5:0] pos_q, pos_d;
  logic [CNT_W-1:0] wc_q, wc_d, ic_q, ic_d;
  logic adv, xfer, arm;

  prbs7_word_gen u_word (.state_i(state_q), .word_o(clean));

  // next-state: advance/hold/idle flow control, injection arming and counters
  always_comb begin
    adv = en & (!valid_q | dout_ready) & !seed_load;
    xfer = valid_q & dout_ready;
    arm = inj_req & (!pend_q | adv);
    mask = pend_q ? ({{(WORD_W-1){1'b0}}, 1'b1} << pos_q) : '0;
    state_d = seed_load ? prbs7_fix_seed(seed_in) : adv ? clean[WORD_W-1:WORD_W-PRBS7_W] : state_q;
    dout_d = adv ? clean ^ mask : dout_q;
    valid_d = seed_load ? 1'b0 : adv ? 1'b1 : valid_q & !dout_ready;
    flag_d = adv ? pend_q : flag_q;
    pend_d = arm | (pend_q & !adv);
    pos_d = arm ? inj_pos : pos_q;
    wc_d = wc_q + CNT_W'(xfer);
    ic_d = ic_q + CNT_W'(xfer & flag_q);
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= prbs7_fix_seed(SEED);
      dout_q <= '0;
      valid_q <= 1'b0;
      pend_q <= 1'b0;
      flag_q <= 1'b0;
      pos_q <= '0;
      wc_q <= '0;
      ic_q <= '0;
    end else begin
      state_q <= state_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      pend_q <= pend_d;
      flag_q <= flag_d;
      pos_q <= pos_d;
      wc_q <= wc_d;
      ic_q <= ic_d;
    end
  end

  assign dout = dout_q;
  assign dout_valid = valid_q;
  assign inj_pending = pend_q;
  assign word_cnt = wc_q;
  assign inj_cnt = ic_q;
endmodule

// File: tb/tb_prbs7_gen.sv
// tb_prbs7_gen: directed self-checking bench for prbs7_gen
module tb_prbs7_gen;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, seed_load = 1'b0, inj_req = 1'b0, dout_ready = 1'b0;
  logic [6:0] seed_in = '0;
  logic [5:0] inj_pos = '0;
  logic [63:0] dout;
  logic dout_valid, inj_pending;
  logic [31:0] word_cnt, inj_cnt;
  int n_cmp = 0, n_err = 0;
  logic [6:0] ms;
  logic [63:0] w1, held;

  prbs7_gen dut (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .inj_req(inj_req), .inj_pos(inj_pos), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .inj_pending(inj_pending), .word_cnt(word_cnt), .inj_cnt(inj_cnt)
  );

  always #5 clk = ~clk;

  // bit-serial reference: stream b[k+7] = b[k] ^ b[k+1], seeded with the 7 state bits
  function automatic logic [63:0] ref_word(input logic [6:0] s);
    logic [70:0] b;
    b = '0;
    b[6:0] = s;
    for (int k = 0; k < 64; k++) b[k+7] = b[k] ^ b[k+1];
    return b[70:7];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic adv_chk(input string tag, input logic [63:0] m);
    logic [63:0] w;
    cyc();
    w = ref_word(ms);
    chk(tag, dout, w ^ m);
    ms = w[63:57];
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_dout", dout, 64'd0);
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_pend", 64'(inj_pending), 64'd0);
    chk("rst_wcnt", 64'(word_cnt), 64'd0);
    chk("rst_icnt", 64'(inj_cnt), 64'd0);
    rst = 1'b0; en = 1'b1; dout_ready = 1'b1; ms = 7'h7F;
    adv_chk("word1", 64'd0);
    w1 = dout;
    chk("first_valid", 64'(dout_valid), 64'd1);
    chk("first_low7", 64'(dout[6:0]), 64'h40);
    for (int i = 2; i <= 127; i++) adv_chk("stream", 64'd0);
    chk("period_state", 64'(ms), 64'h7F);
    adv_chk("word128", 64'd0);
    chk("word128_eq_w1", dout, w1);
    chk("wcnt_128", 64'(word_cnt), 64'd127);
    dout_ready = 1'b0; held = dout;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_dout", dout, held);
      chk("bp_valid", 64'(dout_valid), 64'd1);
    end
    chk("bp_wcnt", 64'(word_cnt), 64'd127);
    dout_ready = 1'b1;
    adv_chk("bp_resume", 64'd0);
    chk("bp_wcnt_after", 64'(word_cnt), 64'd128);
    inj_req = 1'b1; inj_pos = 6'd0;
    adv_chk("inj_arm_clean", 64'd0);
    chk("inj_pend_set", 64'(inj_pending), 64'd1);
    inj_req = 1'b0;
    adv_chk("inj_bit0", 64'd1);
    chk("inj_pend_clr", 64'(inj_pending), 64'd0);
    adv_chk("inj_after_clean", 64'd0);
    chk("inj_cnt1", 64'(inj_cnt), 64'd1);
    inj_req = 1'b1; inj_pos = 6'd5;
    adv_chk("dbl_arm", 64'd0);
    dout_ready = 1'b0; inj_pos = 6'd9; held = dout;
    cyc();
    chk("dbl_hold", dout, held);
    chk("dbl_pend", 64'(inj_pending), 64'd1);
    inj_req = 1'b0; dout_ready = 1'b1;
    adv_chk("dbl_bit5", 64'd1 << 5);
    adv_chk("dbl_clean", 64'd0);
    chk("dbl_icnt", 64'(inj_cnt), 64'd2);
    inj_req = 1'b1; inj_pos = 6'd3;
    adv_chk("rearm_arm", 64'd0);
    inj_pos = 6'd12;
    adv_chk("rearm_bit3", 64'd1 << 3);
    chk("rearm_pend", 64'(inj_pending), 64'd1);
    inj_req = 1'b0;
    adv_chk("rearm_bit12", 64'd1 << 12);
    adv_chk("rearm_clean", 64'd0);
    chk("rearm_icnt", 64'(inj_cnt), 64'd4);
    chk("rearm_pend_clr", 64'(inj_pending), 64'd0);
    seed_load = 1'b1; seed_in = 7'h00;
    cyc();
    chk("seed0_valid", 64'(dout_valid), 64'd0);
    seed_load = 1'b0; ms = 7'h7F;
    adv_chk("seed0_word", 64'd0);
    chk("seed0_eq_w1", dout, w1);
    dout_ready = 1'b0; seed_load = 1'b1; seed_in = 7'h15;
    cyc();
    chk("seed_bp_valid", 64'(dout_valid), 64'd0);
    seed_load = 1'b0; ms = 7'h15;
    adv_chk("seed15_word", 64'd0);
    dout_ready = 1'b1;
    adv_chk("seed15_next", 64'd0);
    dout_ready = 1'b0; en = 1'b0; held = dout;
    cyc();
    chk("en0_hold_valid", 64'(dout_valid), 64'd1);
    chk("en0_hold_dout", dout, held);
    dout_ready = 1'b1;
    cyc();
    chk("en0_idle_valid", 64'(dout_valid), 64'd0);
    cyc();
    chk("en0_idle_valid2", 64'(dout_valid), 64'd0);
    en = 1'b1;
    adv_chk("en1_continue", 64'd0);
    inj_req = 1'b1; inj_pos = 6'd7;
    adv_chk("pre_rst", 64'd0);
    inj_req = 1'b0; rst = 1'b1;
    cyc();
    chk("mrst_dout", dout, 64'd0);
    chk("mrst_valid", 64'(dout_valid), 64'd0);
    chk("mrst_pend", 64'(inj_pending), 64'd0);
    chk("mrst_wcnt", 64'(word_cnt), 64'd0);
    chk("mrst_icnt", 64'(inj_cnt), 64'd0);
    rst = 1'b0; ms = 7'h7F;
    adv_chk("mrst_word1", 64'd0);
    chk("mrst_eq_w1", dout, w1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/prbs7_gen.md
# prbs7_gen

Parallel 64-bit PRBS7 pattern generator (polynomial x^7+x^6+1) that drives the SERDES transmit word path. It is the transmit end of the PRBS7 link test: its output is bit-compatible with the self-seeding 64-bit PRBS7 checker on the receive side. It adds valid/ready flow control, seed loading and single-bit error injection with counters for BER measurements.

## Interface
- `SEED`, default 7'h7F: LFSR state after reset; a zero value is replaced by 7'h7F.
- `CNT_W`, default 32: width of the word and injection counters.

- `clk`  in  1  word clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  generation enable.
- `seed_load`  in  1  load `seed_in` into the LFSR state.
- `seed_in`  in  7  seed value; zero is replaced by 7'h7F.
- `inj_req`  in  1  request a single-bit error in a future word.
- `inj_pos`  in  6  bit index to flip; sampled together with `inj_req`.
- `dout`  out  64  PRBS word; bit 0 is the earliest bit in the stream.
- `dout_valid`  out  1  `dout` holds a word.
- `dout_ready`  in  1  downstream accepts the word.
- `inj_pending`  out  1  an injection is armed and not yet applied.
- `word_cnt`  out  CNT_W  count of transferred words.
- `inj_cnt`  out  CNT_W  count of injected errors that were transferred.

## Operation
- **State.** The 7-bit state s holds the last 7 clean stream bits; s[0] is the oldest.
- **Word computation.** For i = 0..63: bit b_i = s[1]^s[0], then s = {b_i, s[6:1]}. This is equivalent to stream bit b[k] = b[k-7]^b[k-6].
- **State after a word.** The state becomes clean_word[63:57].
- **Advance condition.** Advance when en & (!dout_valid | dout_ready) & !seed_load. On advance:
  - `dout` <= clean_word ^ injection mask;
  - `dout_valid` <= 1;
  - state <= clean_word[63:57].
- **Hold.** If `dout_valid` is 1 and `dout_ready` is 0, then `dout`, the state and `dout_valid` all hold.
- **Idle.** If `en` is 0 and the slot is free (!dout_valid | dout_ready), `dout_valid` <= 0 and the state holds.
- **Injection never corrupts the LFSR state.** The next word is always computed from clean bits.
- **Injection arming.**
  - `inj_req` while `inj_pending` is 0: sets `inj_pending` and latches `inj_pos`.
  - `inj_req` while `inj_pending` is 1: ignored; position and count are unchanged.
- **Injection application.** On the next advance, the mask bit at the latched position is set and `inj_pending` clears on that edge. An `inj_req` in that same cycle re-arms the injection with the new position.
- **Seed load.** `seed_load` (priority over advance) loads state <= (seed_in==0 ? 7'h7F : seed_in) and `dout_valid` <= 0. It does not clear the counters or `inj_pending`.
- **Counters.**
  - `word_cnt` increments on every transfer (dout_valid & dout_ready).
  - `inj_cnt` increments on a transfer of a word that carried an injection.
  - Both wrap modulo 2^CNT_W.
- **Reset values.** `dout`=0, `dout_valid`=0, `inj_pending`=0, `word_cnt`=0, `inj_cnt`=0, state=SEED (0 maps to 7'h7F). `rst` overrides all other inputs.
- **Stream period.** The stream repeats every 127 bits, so the word sequence repeats every 127 words.

## Timing
- **Latency.** If `en` rises at edge t with the slot free, `dout_valid` is 1 after edge t. A new word follows each cycle while `dout_ready` is 1: full throughput, one word per clock.
- **Backpressure.** `dout` is stable while dout_valid & !dout_ready. There is no combinational path from `dout_ready` to `dout`.
- **Injection timing.** `inj_req` at edge t affects the first word loaded at or after edge t+1. It never affects the word loaded at edge t itself.
- **Seed timing.** `seed_load` at edge t: the first word from the new seed is loaded at edge t+1 if `en` is 1.
- **Reset mid-transfer.** `rst` mid-transfer drops the word in flight; no counter increments for it.
- **Counter timing.** Counter updates are visible one cycle after the transfer edge.

## Structure
- **Package `prbs7_pkg`:**
  - `PRBS7_W` = 7;
  - `WORD_W` = 64;
  - `PRBS7_DEFAULT_SEED` = 7'h7F;
  - a function `prbs7_next_word(state)` returning the 64-bit clean word; the next state is word[63:57].
- **Sub-module `prbs7_word_gen`:** combinational, 7-bit state in, 64-bit clean word out (64-step unroll). It is reusable by future checkers.
- **Top level:** registers, flow control, injection and counters.

## Test plan
- **Reset and first word.** `rst` then en=1, ready=1, SEED=7'h7F → first word has dout[6:0]=7'h40 and dout[63:57] feeds the next word. All 127 words match a bit-serial x^7+x^6+1 reference model; word 128 equals word 1.
- **Backpressure.** ready=0 for 5 cycles mid-stream → `dout` and `dout_valid` hold; after ready=1 the stream continues with no skipped or repeated word. `word_cnt` counts only handshakes.
- **Single injection.** inj_req with inj_pos=0 → exactly one later word differs from the model in bit 0 only; the following words are clean. `inj_cnt`=1; the checker on loopback counts 1 error.
- **Double request.** inj_req twice while pending (positions 5 then 9) → only bit 5 is flipped and `inj_cnt` increments by 1. Re-arming in the apply cycle flips the next word once more.
- **Seed edge cases.** seed_load with seed_in=0 → the stream equals the 7'h7F stream. seed_load during ready=0 → `dout_valid` drops and the next word starts from the new seed.
- **Enable and reset mid-stream.** en=0 mid-stream → `dout_valid` falls after the pending transfer completes and the state is preserved, so re-enabling continues the sequence. `rst` mid-stream → all outputs return to their reset values.
